// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor: one GROUP-bit look-ahead slice per
// stage, group carry and partial sum registered between stages, valid/ready on both sides.
module pipelined_cla_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned GROUP = 4
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   input  logic             sub_in,
   output logic             valid_out,
   input  logic             ready_in,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             overflow_out
);

   localparam int unsigned STAGES = WIDTH / GROUP;

   // Look-ahead carries of one slice, each carry a flat sum of products (no ripple).
   function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] g,
                                                  input logic [GROUP-1:0] p,
                                                  input logic             cin);
      logic [GROUP:0] c;
      logic           term;
      c    = '0;
      c[0] = cin;
      for (int unsigned j = 0; j < GROUP; j++) begin
         term = cin;
         for (int unsigned i = 0; i <= j; i++) term = term & p[i];
         c[j+1] = term;
         for (int unsigned i = 0; i <= j; i++) begin
            term = g[i];
            for (int unsigned m = i + 1; m <= j; m++) term = term & p[m];
            c[j+1] = c[j+1] | term;
         end
      end
      return c;
   endfunction

   // Operands shift down by GROUP per stage; the sum fills in from the top.
   logic [WIDTH-1:0] r_a   [STAGES];
   logic [WIDTH-1:0] r_b   [STAGES];
   logic [WIDTH-1:0] r_sum [STAGES];
   logic             r_c   [STAGES];
   logic             r_v   [STAGES];
   logic             r_ovf;

   logic [WIDTH-1:0] w_a      [STAGES];
   logic [WIDTH-1:0] w_b      [STAGES];
   logic [WIDTH-1:0] w_sum_in [STAGES];
   logic             w_cin    [STAGES];
   logic             w_vin    [STAGES];
   logic [GROUP:0]   w_c      [STAGES];
   logic [GROUP-1:0] w_s      [STAGES];
   logic             w_advance;

   assign w_advance    = !r_v[STAGES-1] || ready_in;
   assign ready_out    = w_advance;
   assign valid_out    = r_v[STAGES-1];
   assign sum_out      = r_sum[STAGES-1];
   assign carry_out    = r_c[STAGES-1];
   assign overflow_out = r_ovf;

   // Stage sources and per-slice look-ahead evaluation.
   always_comb begin
      w_a[0]      = a_in;
      w_b[0]      = sub_in ? ~b_in : b_in;
      w_cin[0]    = sub_in | c_in;
      w_sum_in[0] = '0;
      w_vin[0]    = valid_in;
      for (int k = 1; k < STAGES; k++) begin
         w_a[k]      = r_a[k-1];
         w_b[k]      = r_b[k-1];
         w_cin[k]    = r_c[k-1];
         w_sum_in[k] = r_sum[k-1];
         w_vin[k]    = r_v[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         w_c[k] = cla_carries(w_a[k][GROUP-1:0] & w_b[k][GROUP-1:0],
                              w_a[k][GROUP-1:0] ^ w_b[k][GROUP-1:0], w_cin[k]);
         w_s[k] = (w_a[k][GROUP-1:0] ^ w_b[k][GROUP-1:0]) ^ w_c[k][GROUP-1:0];
      end
   end

   // Whole pipeline advances or freezes together; data loads only behind a valid bit.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int k = 0; k < STAGES; k++) begin
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_sum[k] <= '0;
            r_c[k]   <= 1'b0;
            r_v[k]   <= 1'b0;
         end
         r_ovf <= 1'b0;
      end else if (w_advance) begin
         for (int k = 0; k < STAGES; k++) begin
            r_v[k] <= w_vin[k];
            if (w_vin[k]) begin
               r_a[k]   <= w_a[k] >> GROUP;
               r_b[k]   <= w_b[k] >> GROUP;
               r_c[k]   <= w_c[k][GROUP];
               r_sum[k] <= (w_sum_in[k] >> GROUP) | (WIDTH'(w_s[k]) << (WIDTH - GROUP));
            end
         end
         if (w_vin[STAGES-1])
            r_ovf <= w_c[STAGES-1][GROUP] ^ w_c[STAGES-1][GROUP-1];
      end
   end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder (WIDTH=16, GROUP=4): directed vectors, stall, bubbles,
// mid-flight reset and random traffic against an arithmetic reference model.
module tb_pipelined_cla_adder;

   logic        clk_in, rst_n_in, valid_in, ready_out, c_in, sub_in;
   logic        valid_out, ready_in, carry_out, overflow_out;
   logic [15:0] a_in, b_in, sum_out;

   pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .ready_out(ready_out),
      .a_in(a_in), .b_in(b_in), .c_in(c_in), .sub_in(sub_in), .valid_out(valid_out),
      .ready_in(ready_in), .sum_out(sum_out), .carry_out(carry_out),
      .overflow_out(overflow_out));

   typedef struct { logic [15:0] sum; logic co; logic ov; } exp_t;
   typedef struct {
      logic [15:0] a; logic [15:0] b; logic c; logic sub;
      logic [15:0] sum; logic co; logic ov;
   } vec_t;

   exp_t        q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_out    = 0;
   logic        mon_stall = 1'b0;
   logic [18:0] mon_prev  = '0;

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the operation's meaning.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic c, input logic sub);
      exp_t        e;
      int          sa, sb, sr;
      logic [16:0] full;
      sa = $signed(a);
      sb = $signed(b);
      if (sub) begin
         e.sum = a - b;
         e.co  = (a >= b);
         sr    = sa - sb;
      end else begin
         full  = {1'b0, a} + {1'b0, b} + {16'd0, c};
         e.sum = full[15:0];
         e.co  = full[16];
         sr    = sa + sb + int'(c);
      end
      e.ov = (sr > 32767) || (sr < -32768);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_op(input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic sub);
      a_in = a; b_in = b; c_in = c; sub_in = sub;
   endtask

   task automatic set_rand_op();
      set_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic drain();
      int guard;
      guard    = 0;
      valid_in = 1'b0;
      ready_in = 1'b1;
      while ((q.size() != 0 || valid_out) && guard < 100) begin
         tick();
         guard++;
      end
      chk("drain_empty", 32'(q.size() == 0 && !valid_out), 32'd1);
   endtask

   // Scoreboard and handshake monitor, sampled mid-cycle.
   always @(negedge clk_in) begin
      exp_t e;
      if (rst_n_in) begin
         chk("ready_rule", 32'(ready_out), 32'(!valid_out || ready_in));
         if (mon_stall)
            chk("stall_hold", 32'({valid_out, sum_out, carry_out, overflow_out}), 32'(mon_prev));
         if (valid_in && ready_out) q.push_back(model(a_in, b_in, c_in, sub_in));
         if (valid_out && ready_in) begin
            n_out++;
            if (q.size() == 0) begin
               chk("unexpected_result", 32'(sum_out), 32'hFFFF_FFFF);
            end else begin
               e = q.pop_front();
               chk("sb_sum", 32'(sum_out), 32'(e.sum));
               chk("sb_carry", 32'(carry_out), 32'(e.co));
               chk("sb_ovf", 32'(overflow_out), 32'(e.ov));
            end
         end
         mon_stall = valid_out && !ready_in;
         mon_prev  = {valid_out, sum_out, carry_out, overflow_out};
      end else begin
         mon_stall = 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt[8];
      logic        pat[4];
      logic        obs[9];
      logic [18:0] snap;
      int          n0;

      vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[1] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
      vt[2] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vt[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vt[4] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
      vt[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      vt[6] = '{16'h0005, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0};
      vt[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

      rst_n_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
      set_op(16'h0, 16'h0, 1'b0, 1'b0);
      #2;
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_sum", 32'(sum_out), 32'd0);
      chk("rst_carry", 32'(carry_out), 32'd0);
      chk("rst_ovf", 32'(overflow_out), 32'd0);
      chk("rst_ready", 32'(ready_out), 32'd1);
      repeat (2) @(posedge clk_in);
      #1 rst_n_in = 1'b1;
      tick();
      chk("post_rst_valid", 32'(valid_out), 32'd0);
      chk("post_rst_ready", 32'(ready_out), 32'd1);

      // Directed vectors with exact latency: accepted at one edge, valid after the fourth.
      for (int i = 0; i < 8; i++) begin
         set_op(vt[i].a, vt[i].b, vt[i].c, vt[i].sub);
         valid_in = 1'b1;
         tick();
         valid_in = 1'b0;
         for (int e = 1; e <= 3; e++) begin
            chk("latency_early", 32'(valid_out), 32'd0);
            tick();
         end
         chk("latency_valid", 32'(valid_out), 32'd1);
         chk("vec_sum", 32'(sum_out), 32'(vt[i].sum));
         chk("vec_carry", 32'(carry_out), 32'(vt[i].co));
         chk("vec_ovf", 32'(overflow_out), 32'(vt[i].ov));
         tick();
      end

      // Back-to-back stream of 8, then a 3-cycle stall with a result waiting.
      n0 = n_out;
      valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_rand_op();
         tick();
      end
      valid_in = 1'b0;
      ready_in = 1'b0;
      chk("stall_entry_valid", 32'(valid_out), 32'd1);
      snap = {valid_out, sum_out, carry_out, overflow_out};
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_ready", 32'(ready_out), 32'd0);
         chk("stall_frozen", 32'({valid_out, sum_out, carry_out, overflow_out}), 32'(snap));
      end
      ready_in = 1'b1;
      drain();
      chk("stream_count", 32'(n_out - n0), 32'd8);

      // Bubbles 1,0,1,0 reappear at the output four edges after presentation.
      pat = '{1'b1, 1'b0, 1'b1, 1'b0};
      obs[0] = valid_out;
      for (int i = 0; i < 4; i++) begin
         valid_in = pat[i];
         set_rand_op();
         tick();
         obs[i+1] = valid_out;
      end
      valid_in = 1'b0;
      for (int i = 5; i <= 8; i++) begin
         tick();
         obs[i] = valid_out;
      end
      for (int i = 0; i < 4; i++) chk("bubble_pattern", 32'(obs[i+4]), 32'(pat[i]));
      drain();

      // Reset between edges with a full pipeline: outputs clear at once, nothing resurfaces.
      n0 = n_out;
      valid_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_op(16'hFFFF, 16'(i + 1), 1'b1, 1'b0);
         tick();
      end
      valid_in = 1'b0;
      #1 rst_n_in = 1'b0;
      #1;
      chk("midrst_valid", 32'(valid_out), 32'd0);
      chk("midrst_sum", 32'(sum_out), 32'd0);
      chk("midrst_carry", 32'(carry_out), 32'd0);
      chk("midrst_ovf", 32'(overflow_out), 32'd0);
      q.delete();
      #1 rst_n_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("midrst_no_ghost", 32'(valid_out), 32'd0);
      end
      chk("midrst_ready", 32'(ready_out), 32'd1);
      set_op(16'h00F0, 16'h0F10, 1'b0, 1'b0);
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      drain();
      chk("midrst_count", 32'(n_out - n0), 32'd1);

      // Random traffic with random backpressure, checked by the scoreboard.
      for (int i = 0; i < 300; i++) begin
         valid_in = ($urandom_range(0, 9) < 7);
         ready_in = ($urandom_range(0, 3) != 0);
         set_rand_op();
         tick();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
